result_bcd_display: RTL

Downstream consumer of the memory-mapped result register (address 0x200) in the calculator top level. On each processor write to the result register, this block captures the value and converts it from binary to decimal BCD with a sequential double-dabble engine, one shift per cycle. It then drives decimal 7-segment patterns, with a sign indicator and leading-zero blanking, in place of the raw hex nibbles. Displayed outputs hold the previous result until a new conversion completes, so the displays never flicker.

---
 rtl/result_bcd_display.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/result_bcd_display.sv
// Captures a written result value and converts it to BCD with a serial double-dabble engine.
// Drives decimal 7-segment digits with a sign indicator and leading-zero blanking.
module result_bcd_display #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [31:0]         data_in,
  output logic                busy,
  output logic                valid,
  output logic                done,
  output logic                neg,
  output logic [4*DIGITS-1:0] bcd,
  output logic [7*DIGITS-1:0] seg,
  output logic [6:0]          seg_sign
);

  localparam int SW = WIDTH + 4*DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 4 || WIDTH > 32 || WIDTH * 30103 > DIGITS * 100000) begin : g_param_err
    $error("result_bcd_display: WIDTH out of range or too few DIGITS for WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CONVERT = 2'd1, S_DONE = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic [SW-1:0]       r_shift;
  logic [CW-1:0]       r_cnt;
  logic                r_pend;
  logic [WIDTH-1:0]    r_pend_data;
  logic                r_neg_work;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_neg, r_valid, r_done;
  logic                w_start;
  logic [WIDTH-1:0]    w_src;
  logic [WIDTH:0]      w_cap;
  logic                w_shown;
  logic                w_unused;

  // Returns {sign, magnitude}; the most negative value maps to its full magnitude.
  function automatic logic [WIDTH:0] capture(input logic [WIDTH-1:0] d);
    if (SIGNED != 0 && d[WIDTH-1]) return {1'b1, ~d + WIDTH'(1)};
    return {1'b0, d};
  endfunction

  function automatic logic [SW-1:0] dabble(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (t[WIDTH+4*k +: 4] >= 4'd5) t[WIDTH+4*k +: 4] = t[WIDTH+4*k +: 4] + 4'd3;
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign w_unused = ^data_in;

  // A load seen in DONE is consumed at once, taking priority over buffered data.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_state_nxt = S_CONVERT;
          w_start     = 1'b1;
        end
      end
      S_CONVERT: begin
        if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (r_pend || load) begin
          w_state_nxt = S_CONVERT;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_src = (r_state == S_DONE && !load) ? r_pend_data : data_in[WIDTH-1:0];
  assign w_cap = capture(w_src);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_bcd   <= '0;
      r_neg   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (w_start)                     r_cnt <= CW'(WIDTH);
      else if (r_state == S_CONVERT)   r_cnt <= r_cnt - CW'(1);
      if (r_state == S_CONVERT && load) r_pend <= 1'b1;
      else if (r_state == S_DONE)       r_pend <= 1'b0;
      if (r_state == S_DONE) begin
        r_bcd   <= r_shift[SW-1:WIDTH];
        r_neg   <= r_neg_work;
        r_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_shift    <= {{(4*DIGITS){1'b0}}, w_cap[WIDTH-1:0]};
      r_neg_work <= w_cap[WIDTH];
    end else if (r_state == S_CONVERT) begin
      r_shift <= dabble(r_shift);
    end
    if (load && r_state == S_CONVERT) r_pend_data <= data_in[WIDTH-1:0];
  end

  // Scan from the top digit down; once a nonzero digit appears, everything below is shown.
  always_comb begin
    seg     = '1;
    w_shown = 1'b0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      w_shown = w_shown | (r_bcd[4*i +: 4] != 4'd0) | (i == 0);
      if (w_shown) seg[7*i +: 7] = glyph(r_bcd[4*i +: 4]);
    end
  end

  assign busy     = (r_state != S_IDLE) || r_pend;
  assign valid    = r_valid;
  assign done     = r_done;
  assign neg      = r_neg;
  assign bcd      = r_bcd;
  assign seg_sign = r_neg ? 7'b0111111 : 7'b1111111;

endmodule
